// File: rtl/exe_pipeline_controller_pkg.sv
// Shared types and constants for the execute-stage pipeline controller.
package exe_pipeline_controller_pkg;

  localparam int unsigned REG_W = 4;

  // Register index of the PC; values for it are never forwarded.
  localparam logic [REG_W-1:0] PC_REG = 4'hF;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_e;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;

endpackage

// File: rtl/exe_pipeline_controller_hazard_fwd_detect.sv
// Combinational RAW hazard detection and ALU operand forwarding selects.
module hazard_fwd_detect
  import exe_pipeline_controller_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_wb_en,
  output logic             raw_stall,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2
);

  logic exe_hit;
  logic mem_hit;

  // MEM result beats WB value; the PC is never a forwarding target.
  function automatic logic [1:0] pick_fwd(input logic [REG_W-1:0] src,
                                          input logic [REG_W-1:0] m_dest,
                                          input logic             m_wb,
                                          input logic [REG_W-1:0] w_dest,
                                          input logic             w_wb);
    logic [1:0] sel;
    sel = FWD_REGFILE;
    if (src != PC_REG) begin
      if (m_wb && (m_dest == src))      sel = FWD_MEM;
      else if (w_wb && (w_dest == src)) sel = FWD_WB;
    end
    return sel;
  endfunction

  // Source-vs-destination compares and stall decision.
  always_comb begin
    exe_hit = id_valid & exe_wb_en &
              ((id_src1 == exe_dest) | (id_two_src & (id_src2 == exe_dest)));
    mem_hit = id_valid & mem_wb_en &
              ((id_src1 == mem_dest) | (id_two_src & (id_src2 == mem_dest)));
    if (FWD_EN) raw_stall = exe_hit & exe_mem_r_en;
    else        raw_stall = exe_hit | mem_hit;
  end

  // Operand source selection; regfile only when forwarding is disabled.
  always_comb begin
    fwd_sel1 = FWD_REGFILE;
    fwd_sel2 = FWD_REGFILE;
    if (FWD_EN) begin
      fwd_sel1 = pick_fwd(id_src1, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
      fwd_sel2 = pick_fwd(id_src2, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
    end
  end

endmodule

// File: rtl/exe_pipeline_controller.sv
// Hazard, flush and freeze sequencer with memory-wait FSM and perf counters.
module exe_pipeline_controller
  import exe_pipeline_controller_pkg::*;
#(
  parameter bit          FWD_EN      = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic             exe_branch_taken,
  input  logic             exe_s,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_wb_en,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             freeze_all,
  output logic             sr_we,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1) + 1;

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               raw_stall;

  hazard_fwd_detect #(.FWD_EN(FWD_EN)) u_detect (
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .wb_dest      (wb_dest),
    .wb_wb_en     (wb_wb_en),
    .raw_stall    (raw_stall),
    .fwd_sel1     (fwd_sel1),
    .fwd_sel2     (fwd_sel2)
  );

  // Priority strobes: memory freeze, then branch flush, then RAW stall.
  // The wait freeze drops in the cycle mem_ready rises so any pending branch
  // or hazard is acted on in that same cycle.
  always_comb begin
    freeze_pc    = 1'b0;
    freeze_if_id = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;
    freeze_all   = ((state_q == RUN) & mem_req & ~mem_ready) |
                   ((state_q == MEM_WAIT) & ~mem_ready) |
                   (state_q == MEM_ERR);
    if (!freeze_all) begin
      if (exe_branch_taken) begin
        flush_if_id  = 1'b1;
        flush_id_exe = 1'b1;
      end else if (raw_stall) begin
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
        flush_id_exe = 1'b1;
      end
    end
    sr_we     = exe_s & ~freeze_all;
    mem_error = (state_q == MEM_ERR);
    stall_cnt = stall_cnt_q;
    flush_cnt = flush_cnt_q;
  end

  // Memory-wait FSM next state and saturating counter updates.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCNT_W'(MEM_TIMEOUT)) begin
          state_d = MEM_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      MEM_ERR: state_d = MEM_ERR;
      default: state_d = RUN;
    endcase
    if ((freeze_pc || freeze_all) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_if_id && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_exe_pipeline_controller.sv
// Directed table-driven bench for exe_pipeline_controller.
module tb_exe_pipeline_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_two_src, exe_wb_en, exe_mem_r_en, exe_branch_taken;
  logic       exe_s, mem_wb_en, mem_req, mem_ready, wb_wb_en;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest, wb_dest;

  logic        freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_all, sr_we, mem_error;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic [15:0] stall_cnt, flush_cnt;

  logic        n_freeze_pc, n_freeze_if_id, n_flush_if_id, n_flush_id_exe, n_freeze_all, n_sr_we, n_mem_error;
  logic [1:0]  n_fwd_sel1, n_fwd_sel2;
  logic [3:0]  n_stall_cnt, n_flush_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  exe_pipeline_controller #(.FWD_EN(1'b1), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .exe_branch_taken(exe_branch_taken), .exe_s(exe_s),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id),
    .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe), .freeze_all(freeze_all),
    .sr_we(sr_we), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .mem_error(mem_error),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // No-forwarding variant with narrow counters.
  exe_pipeline_controller #(.FWD_EN(1'b0), .MEM_TIMEOUT(15), .CNT_W(4)) dut_nf (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .exe_branch_taken(exe_branch_taken), .exe_s(exe_s),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .freeze_pc(n_freeze_pc), .freeze_if_id(n_freeze_if_id),
    .flush_if_id(n_flush_if_id), .flush_id_exe(n_flush_id_exe), .freeze_all(n_freeze_all),
    .sr_we(n_sr_we), .fwd_sel1(n_fwd_sel1), .fwd_sel2(n_fwd_sel2), .mem_error(n_mem_error),
    .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
  );

  typedef struct {
    string      name;
    logic       idv;  logic [3:0] s1; logic [3:0] s2; logic two;
    logic [3:0] ed;   logic ewb;  logic emr;  logic br;  logic s;
    logic [3:0] md;   logic mwb;  logic [3:0] wd; logic wwb;
    logic       x_fpc; logic x_fifid; logic x_flifid; logic x_flide; logic x_sr;
    logic [1:0] x_f1;  logic [1:0] x_f2;
    logic       x_nf_fpc; logic [1:0] x_nf_f2;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0; exe_branch_taken = 0; exe_s = 0;
    mem_dest = 0; mem_wb_en = 0; mem_req = 0; mem_ready = 0; wb_dest = 0; wb_wb_en = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    id_valid = v.idv; id_src1 = v.s1; id_src2 = v.s2; id_two_src = v.two;
    exe_dest = v.ed; exe_wb_en = v.ewb; exe_mem_r_en = v.emr; exe_branch_taken = v.br;
    exe_s = v.s; mem_dest = v.md; mem_wb_en = v.mwb; wb_dest = v.wd; wb_wb_en = v.wwb;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"}, {31'd0, freeze_pc | freeze_if_id | flush_if_id | flush_id_exe | freeze_all | sr_we}, 32'd0);
    check({tag, "_err"}, {31'd0, mem_error}, 32'd0);
    check({tag, "_stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
    check({tag, "_flush_cnt"}, {16'd0, flush_cnt}, 32'd0);
    check({tag, "_nf_cnts"}, {24'd0, n_stall_cnt, n_flush_cnt}, 32'd0);
  endtask

  initial begin
    //        name        idv s1 s2 two ed ewb emr br s  md mwb wd wwb fpc fid fl fe sr f1     f2     nfpc nf2
    vecs[0]  = '{"idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00};
    vecs[1]  = '{"load_use",  1, 3, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 2'b00, 2'b00, 1, 2'b00};
    vecs[2]  = '{"alu_raw",   1, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00};
    vecs[3]  = '{"fwd_mem",   1, 1, 5, 1, 0, 0, 0, 0, 0, 5, 1, 5, 1,  0, 0, 0, 0, 0, 2'b00, 2'b01, 1, 2'b00};
    vecs[4]  = '{"fwd_wb",    1, 1, 5, 1, 0, 0, 0, 0, 0, 5, 0, 5, 1,  0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 2'b00};
    vecs[5]  = '{"src2_off",  1, 1, 5, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00};
    vecs[6]  = '{"src2_on",   1, 1, 5, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 2'b00, 2'b00, 1, 2'b00};
    vecs[7]  = '{"id_inval",  0, 3, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00};
    vecs[8]  = '{"r15_nofwd", 0,15, 2, 0, 0, 0, 0, 0, 0,15, 1,15, 1,  0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00};
    vecs[9]  = '{"sr_we",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00};
    vecs[10] = '{"br_hazard", 1, 3, 0, 0, 3, 1, 1, 1, 1, 0, 0, 0, 0,  0, 0, 1, 1, 1, 2'b00, 2'b00, 0, 2'b00};
    vecs[11] = '{"mem_gt_wb", 1, 7, 2, 0, 0, 0, 0, 0, 0, 7, 1, 7, 1,  0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 2'b00};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state.
    do_reset();
    #1;
    check_all_zero("reset");

    // Combinational vector table.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      #1;
      check({vecs[i].name, "_strobes"},
            {27'd0, freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, sr_we},
            {27'd0, vecs[i].x_fpc, vecs[i].x_fifid, vecs[i].x_flifid, vecs[i].x_flide, vecs[i].x_sr});
      check({vecs[i].name, "_freeze_all"}, {31'd0, freeze_all}, 32'd0);
      check({vecs[i].name, "_fwd"}, {28'd0, fwd_sel1, fwd_sel2}, {28'd0, vecs[i].x_f1, vecs[i].x_f2});
      check({vecs[i].name, "_nf"}, {29'd0, n_freeze_pc, n_fwd_sel2}, {29'd0, vecs[i].x_nf_fpc, vecs[i].x_nf_f2});
    end

    // Load-use single-cycle stall counting.
    do_reset();
    drive_vec(vecs[1]);
    @(negedge clk);
    idle_inputs();
    #1;
    check("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    check("lu_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    check("lu_released", {31'd0, freeze_pc}, 32'd0);

    // Branch with simultaneous load-use.
    do_reset();
    drive_vec(vecs[10]);
    @(negedge clk);
    idle_inputs();
    #1;
    check("br_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    check("br_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    // Memory wait of three cycles with a branch pending.
    do_reset();
    mem_req = 1; mem_ready = 0; exe_s = 1; exe_branch_taken = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("mw_freeze_all", {31'd0, freeze_all}, 32'd1);
      check("mw_quiet", {29'd0, sr_we, flush_if_id, freeze_pc}, 32'd0);
      @(negedge clk);
    end
    mem_ready = 1;
    #1;
    check("mw_release", {30'd0, freeze_all, sr_we}, 32'd1);
    check("mw_branch_acted", {31'd0, flush_if_id}, 32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    check("mw_back_run", {31'd0, freeze_all}, 32'd0);
    check("mw_stall_cnt", {16'd0, stall_cnt}, 32'd3);
    check("mw_flush_cnt", {16'd0, flush_cnt}, 32'd1);

    // Timeout into the sticky error state.
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("to_err_k%0d", k), {31'd0, mem_error}, {31'd0, (k >= 16)});
    end
    @(negedge clk);
    mem_req = 0; mem_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    check("to_sticky", {30'd0, mem_error, freeze_all}, 32'd3);
    check("to_sr_blocked", {31'd0, sr_we}, 32'd0);
    do_reset();
    #1;
    check_all_zero("to_reset");

    // Counter saturation on the 4-bit no-forwarding instance.
    do_reset();
    drive_vec(vecs[2]);
    repeat (20) @(negedge clk);
    idle_inputs();
    #1;
    check("sat_nf_stall", {28'd0, n_stall_cnt}, 32'd15);
    check("sat_main_stall", {16'd0, stall_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
